// File: rtl/light_sequence_monitor.sv
// -----------------------------------------------------------------------------
// light_sequence_monitor
//
// Passive receive-side checker for the one-hot traffic-light bus. Every clock
// the observed bus is decoded back to a phase code and compared with the phase
// currently being tracked. The block reports:
//   - whether the bus is one-hot,
//   - whether the phase order is green -> yellow -> red -> green,
//   - how long the current phase has persisted (dwell),
//   - how many complete red -> green cycles have been seen.
// The block never drives the observed bus.
//
// Parameters
//   CNT_W      width of the completed-cycle counter (wraps)
//   DW_W       width of the dwell counter (saturates); MAX_DWELL < 2**DW_W-1
//   MAX_DWELL  longest legal run of identical samples in one phase
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   light[2:0]   in   observed bus: green 100, yellow 010, red 001
//   phase[1:0]   out  decoded phase: 00 green, 01 yellow, 10 red, 11 none
//   valid        out  1 while a legal sequence is being tracked
//   dwell        out  consecutive samples of the current phase (saturating)
//   cycle_count  out  legal red -> green transitions (wrapping)
//   err_onehot   out  pulse: a tracked bus went non-one-hot
//   err_order    out  pulse: one-hot value that is not the expected successor
//   err_dwell    out  pulse: dwell has just exceeded MAX_DWELL
//   err_any      out  sticky OR of all error pulses, cleared only by reset
// -----------------------------------------------------------------------------
module light_sequence_monitor #(
    parameter int CNT_W     = 8,
    parameter int DW_W      = 8,
    parameter int MAX_DWELL = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       light,
    output logic [1:0]       phase,
    output logic             valid,
    output logic [DW_W-1:0]  dwell,
    output logic [CNT_W-1:0] cycle_count,
    output logic             err_onehot,
    output logic             err_order,
    output logic             err_dwell,
    output logic             err_any
);

    typedef enum logic {
        IDLE  = 1'b0,
        TRACK = 1'b1
    } state_t;

    localparam logic [1:0] PH_GREEN  = 2'b00;
    localparam logic [1:0] PH_YELLOW = 2'b01;
    localparam logic [1:0] PH_RED    = 2'b10;
    localparam logic [1:0] PH_NONE   = 2'b11;

    localparam logic [DW_W-1:0]  DW_ZERO  = {DW_W{1'b0}};
    localparam logic [DW_W-1:0]  DW_ONE   = DW_W'(1);
    localparam logic [DW_W-1:0]  DW_SAT   = {DW_W{1'b1}};
    localparam logic [DW_W-1:0]  DW_LIMIT = DW_W'(MAX_DWELL);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Map a bus value to its phase code; anything not one-hot maps to PH_NONE.
    function automatic logic [1:0] decode_light(input logic [2:0] l);
        logic [1:0] p;
        case (l)
            3'b100:  p = PH_GREEN;
            3'b010:  p = PH_YELLOW;
            3'b001:  p = PH_RED;
            default: p = PH_NONE;
        endcase
        return p;
    endfunction

    // The phase that must legally follow the given one.
    function automatic logic [1:0] next_phase(input logic [1:0] p);
        logic [1:0] n;
        case (p)
            PH_GREEN:  n = PH_YELLOW;
            PH_YELLOW: n = PH_RED;
            PH_RED:    n = PH_GREEN;
            default:   n = PH_NONE;
        endcase
        return n;
    endfunction

    state_t           state_r;
    logic [1:0]       phase_r;
    logic             valid_r;
    logic [DW_W-1:0]  dwell_r;
    logic [CNT_W-1:0] cycle_count_r;
    logic             err_onehot_r;
    logic             err_order_r;
    logic             err_dwell_r;
    logic             err_any_r;

    logic [1:0]       sample_ph_s;
    logic             sample_onehot_s;
    logic             same_phase_s;
    logic             successor_s;

    assign sample_ph_s     = decode_light(light);
    assign sample_onehot_s = (sample_ph_s != PH_NONE);
    assign same_phase_s    = (sample_ph_s == phase_r);
    assign successor_s     = (sample_ph_s == next_phase(phase_r));

    // Tracking FSM; every output is a register updated here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            phase_r       <= PH_NONE;
            valid_r       <= 1'b0;
            dwell_r       <= DW_ZERO;
            cycle_count_r <= CNT_ZERO;
            err_onehot_r  <= 1'b0;
            err_order_r   <= 1'b0;
            err_dwell_r   <= 1'b0;
            err_any_r     <= 1'b0;
        end else begin
            // Pulses default low; branches below raise them for one edge.
            err_onehot_r <= 1'b0;
            err_order_r  <= 1'b0;
            err_dwell_r  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (sample_onehot_s) begin
                        // Entry is unconditional: no order check, no cycle count.
                        state_r <= TRACK;
                        phase_r <= sample_ph_s;
                        valid_r <= 1'b1;
                        dwell_r <= DW_ONE;
                    end else begin
                        // The loss of one-hot was already reported on the way in.
                        state_r <= IDLE;
                        phase_r <= PH_NONE;
                        valid_r <= 1'b0;
                        dwell_r <= DW_ZERO;
                    end
                end
                TRACK: begin
                    if (!sample_onehot_s) begin
                        state_r      <= IDLE;
                        phase_r      <= PH_NONE;
                        valid_r      <= 1'b0;
                        dwell_r      <= DW_ZERO;
                        err_onehot_r <= 1'b1;
                        err_any_r    <= 1'b1;
                    end else if (same_phase_s) begin
                        if (dwell_r != DW_SAT) begin
                            dwell_r <= dwell_r + DW_ONE;
                        end else begin
                            dwell_r <= DW_SAT;
                        end
                        // Only the crossing edge is flagged, not every later sample.
                        if (dwell_r == DW_LIMIT) begin
                            err_dwell_r <= 1'b1;
                            err_any_r   <= 1'b1;
                        end else begin
                            err_dwell_r <= 1'b0;
                        end
                    end else if (successor_s) begin
                        phase_r <= sample_ph_s;
                        dwell_r <= DW_ONE;
                        if (phase_r == PH_RED) begin
                            cycle_count_r <= cycle_count_r + CNT_ONE;
                        end else begin
                            cycle_count_r <= cycle_count_r;
                        end
                    end else begin
                        // Out-of-order one-hot value: report and resync to it.
                        phase_r     <= sample_ph_s;
                        dwell_r     <= DW_ONE;
                        valid_r     <= 1'b1;
                        err_order_r <= 1'b1;
                        err_any_r   <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    phase_r <= PH_NONE;
                    valid_r <= 1'b0;
                    dwell_r <= DW_ZERO;
                end
            endcase
        end
    end

    assign phase       = phase_r;
    assign valid       = valid_r;
    assign dwell       = dwell_r;
    assign cycle_count = cycle_count_r;
    assign err_onehot  = err_onehot_r;
    assign err_order   = err_order_r;
    assign err_dwell   = err_dwell_r;
    assign err_any     = err_any_r;

endmodule

// File: tb/tb_light_sequence_monitor.sv
`timescale 1ns/1ps
module tb_light_sequence_monitor;

    typedef struct {
        logic [2:0] light;
        logic [1:0] phase;
        logic       valid;
        logic [7:0] dwell;
        logic [7:0] cc;
        logic       e_oh;
        logic       e_ord;
        logic       e_dw;
        logic       e_any;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic [2:0] light;

    // DUT A: defaults.  DUT B: MAX_DWELL=3.  DUT C: CNT_W=2.
    logic [1:0] ph_a, ph_b, ph_c;
    logic       va_a, va_b, va_c;
    logic [7:0] dw_a, dw_b, dw_c;
    logic [7:0] cc_a, cc_b;
    logic [1:0] cc_c;
    logic       oh_a, oh_b, oh_c, or_a, or_b, or_c, dd_a, dd_b, dd_c, an_a, an_b, an_c;

    int   sel;
    int   n_cmp;
    int   n_fail;
    vec_t sb_q[$];
    vec_t tbl[$];

    light_sequence_monitor u_a (
        .clk(clk), .rst_n(rst_n), .light(light), .phase(ph_a), .valid(va_a),
        .dwell(dw_a), .cycle_count(cc_a), .err_onehot(oh_a), .err_order(or_a),
        .err_dwell(dd_a), .err_any(an_a)
    );

    light_sequence_monitor #(.MAX_DWELL(3)) u_b (
        .clk(clk), .rst_n(rst_n), .light(light), .phase(ph_b), .valid(va_b),
        .dwell(dw_b), .cycle_count(cc_b), .err_onehot(oh_b), .err_order(or_b),
        .err_dwell(dd_b), .err_any(an_b)
    );

    light_sequence_monitor #(.CNT_W(2)) u_c (
        .clk(clk), .rst_n(rst_n), .light(light), .phase(ph_c), .valid(va_c),
        .dwell(dw_c), .cycle_count(cc_c), .err_onehot(oh_c), .err_order(or_c),
        .err_dwell(dd_c), .err_any(an_c)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(input logic [2:0] l, input int ph, input int va,
                                input int dw, input int cc, input int oh,
                                input int od, input int ed, input int an);
        vec_t v;
        v.light = l;
        v.phase = 2'(ph);
        v.valid = 1'(va);
        v.dwell = 8'(dw);
        v.cc    = 8'(cc);
        v.e_oh  = 1'(oh);
        v.e_ord = 1'(od);
        v.e_dw  = 1'(ed);
        v.e_any = 1'(an);
        return v;
    endfunction

    function automatic vec_t observe();
        vec_t v;
        v.light = light;
        case (sel)
            0: begin
                v.phase = ph_a; v.valid = va_a; v.dwell = dw_a; v.cc = cc_a;
                v.e_oh = oh_a; v.e_ord = or_a; v.e_dw = dd_a; v.e_any = an_a;
            end
            1: begin
                v.phase = ph_b; v.valid = va_b; v.dwell = dw_b; v.cc = cc_b;
                v.e_oh = oh_b; v.e_ord = or_b; v.e_dw = dd_b; v.e_any = an_b;
            end
            default: begin
                v.phase = ph_c; v.valid = va_c; v.dwell = dw_c; v.cc = {6'b0, cc_c};
                v.e_oh = oh_c; v.e_ord = or_c; v.e_dw = dd_c; v.e_any = an_c;
            end
        endcase
        return v;
    endfunction

    task automatic check(input string name, input vec_t exp);
        vec_t act;
        act = observe();
        n_cmp++;
        if (act.phase !== exp.phase || act.valid !== exp.valid || act.dwell !== exp.dwell ||
            act.cc !== exp.cc || act.e_oh !== exp.e_oh || act.e_ord !== exp.e_ord ||
            act.e_dw !== exp.e_dw || act.e_any !== exp.e_any) begin
            n_fail++;
            $display("FAIL %s dut=%0d light=%b got ph=%b v=%b dw=%0d cc=%0d oh/or/dw/any=%b%b%b%b want ph=%b v=%b dw=%0d cc=%0d oh/or/dw/any=%b%b%b%b",
                     name, sel, exp.light, act.phase, act.valid, act.dwell, act.cc,
                     act.e_oh, act.e_ord, act.e_dw, act.e_any,
                     exp.phase, exp.valid, exp.dwell, exp.cc,
                     exp.e_oh, exp.e_ord, exp.e_dw, exp.e_any);
        end
    endtask

    // Drive one sample, queue its expectation, and compare one edge later.
    task automatic step(input string name, input vec_t v);
        vec_t exp;
        @(negedge clk);
        light = v.light;
        sb_q.push_back(v);
        @(posedge clk);
        #1;
        exp = sb_q.pop_front();
        check(name, exp);
    endtask

    task automatic run_tbl(input string name);
        for (int i = 0; i < tbl.size(); i++) begin
            step($sformatf("%s[%0d]", name, i), tbl[i]);
        end
        tbl.delete();
    endtask

    // Reset held with the bus toggling; outputs must stay at reset values.
    task automatic do_reset(input string name);
        vec_t rv;
        rv = mk(3'b000, 3, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check({name, "_async"}, rv);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            light = 3'(i + 3);
            @(posedge clk);
            #1;
            check({name, "_hold"}, rv);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        sel    = 0;
        rst_n  = 1'b0;
        light  = 3'b000;

        // ---------------- DUT A: legal run, order, non-one-hot, saturation
        sel = 0;
        do_reset("rst_a");
        tbl.push_back(mk(3'b100, 0, 1, 1, 0, 0, 0, 0, 0));
        for (int r = 0; r < 4; r++) begin
            tbl.push_back(mk(3'b010, 1, 1, 1, r,     0, 0, 0, 0));
            tbl.push_back(mk(3'b001, 2, 1, 1, r,     0, 0, 0, 0));
            tbl.push_back(mk(3'b100, 0, 1, 1, r + 1, 0, 0, 0, 0));
        end
        // green -> red is out of order; resync, then red -> green counts
        tbl.push_back(mk(3'b001, 2, 1, 1, 4, 0, 1, 0, 1));
        tbl.push_back(mk(3'b100, 0, 1, 1, 5, 0, 0, 0, 1));
        // non-one-hot drops tracking; 000 in IDLE does not re-pulse
        tbl.push_back(mk(3'b110, 3, 0, 0, 5, 1, 0, 0, 1));
        tbl.push_back(mk(3'b000, 3, 0, 0, 5, 0, 0, 0, 1));
        tbl.push_back(mk(3'b010, 1, 1, 1, 5, 0, 0, 0, 1));
        // MAX_DWELL=1: second identical sample pulses, third does not
        tbl.push_back(mk(3'b010, 1, 1, 2, 5, 0, 0, 1, 1));
        tbl.push_back(mk(3'b010, 1, 1, 3, 5, 0, 0, 0, 1));
        run_tbl("seq_a");
        // dwell saturates at 255 and never wraps
        for (int i = 4; i <= 260; i++) begin
            step("sat_a", mk(3'b010, 1, 1, (i > 255) ? 255 : i, 5, 0, 0, 0, 1));
        end
        // reset mid-sequence clears sticky state without any pulse
        do_reset("midrst_a");
        step("after_rst_a", mk(3'b001, 2, 1, 1, 0, 0, 0, 0, 0));

        // ---------------- DUT B: MAX_DWELL=3, hold yellow 5 samples
        sel = 1;
        do_reset("rst_b");
        tbl.push_back(mk(3'b010, 1, 1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(3'b010, 1, 1, 2, 0, 0, 0, 0, 0));
        tbl.push_back(mk(3'b010, 1, 1, 3, 0, 0, 0, 0, 0));
        tbl.push_back(mk(3'b010, 1, 1, 4, 0, 0, 0, 1, 1));
        tbl.push_back(mk(3'b010, 1, 1, 5, 0, 0, 0, 0, 1));
        run_tbl("dwell_b");

        // ---------------- DUT C: CNT_W=2 wrap, idle non-one-hot after reset
        sel = 2;
        do_reset("rst_c");
        tbl.push_back(mk(3'b111, 3, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(3'b100, 0, 1, 1, 0, 0, 0, 0, 0));
        for (int r = 1; r <= 5; r++) begin
            tbl.push_back(mk(3'b010, 1, 1, 1, (r - 1) % 4, 0, 0, 0, 0));
            tbl.push_back(mk(3'b001, 2, 1, 1, (r - 1) % 4, 0, 0, 0, 0));
            tbl.push_back(mk(3'b100, 0, 1, 1, r % 4,       0, 0, 0, 0));
        end
        run_tbl("wrap_c");

        if (sb_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL scoreboard_drain left=%0d want=0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/light_sequence_monitor.md
# light_sequence_monitor

Receive-side checker for the one-hot traffic-light bus produced by the light sequencer. It samples `light[2:0]` every clock and decodes it back to a phase code. It checks that the bus is one-hot and follows the green→yellow→red→green order, measures per-phase dwell, counts completed cycles, and flags protocol violations. It sits on the sequencer's output bus as a passive observer and never drives the bus.

## Interface
- `CNT_W`, default 8: width of the completed-cycle counter.
- `DW_W`, default 8: width of the dwell counter. Must satisfy `MAX_DWELL < 2**DW_W - 1`.
- `MAX_DWELL`, default 1: maximum legal consecutive samples in one phase. The default matches the sequencer, which advances every clock.

Ports:
- `clk`  input  1  Single clock; all logic on the rising edge.
- `rst_n`  input  1  Asynchronous, active-low reset.
- `light`  input  3  Observed bus: green=3'b100, yellow=3'b010, red=3'b001.
- `phase`  output  2  Decoded phase: 00 green, 01 yellow, 10 red, 11 none/untracked.
- `valid`  output  1  1 while tracking a legal sequence.
- `dwell`  output  DW_W  Consecutive samples of the current phase; saturating.
- `cycle_count`  output  CNT_W  Count of legal red→green transitions; wraps.
- `err_onehot`  output  1  One-cycle pulse: sampled `light` not one-hot.
- `err_order`  output  1  One-cycle pulse: legal one-hot value, but not the successor.
- `err_dwell`  output  1  One-cycle pulse: dwell exceeded `MAX_DWELL`.
- `err_any`  output  1  Sticky OR of all error pulses; cleared only by reset.

## Operation
The FSM has two states: IDLE (reset state) and TRACK.
- All outputs are registered.
- The sampled bus `light` is compared each edge against the current `phase`.

**Decode**
- 100→00, 010→01, 001→10.
- Any other value (000, 011, 101, 110, 111) is non-one-hot.

**Priority per edge:** non-one-hot > order > dwell.

**IDLE**
- Non-one-hot sample: stay in IDLE. Set `err_onehot` = 1 only if the previous state was TRACK; a non-one-hot sample in IDLE does not re-pulse.
- One-hot sample: go to TRACK, `phase` = decoded value, `dwell` = 1, `valid` = 1.
- No order check on entry. `cycle_count` is not incremented on entry, even when entering on green.

**TRACK**
- Non-one-hot sample:
  - `err_onehot` = 1.
  - Go to IDLE with `phase` = 11, `valid` = 0, `dwell` = 0.
- Same phase as current:
  - `dwell` = `dwell` + 1, saturating at 2**DW_W−1.
  - `err_dwell` pulses on the single edge where `dwell` goes from `MAX_DWELL` to `MAX_DWELL`+1. It does not pulse again while the phase persists.
- Legal successor (green→yellow, yellow→red, red→green):
  - `phase` = successor, `dwell` = 1.
  - On red→green only, `cycle_count` = `cycle_count` + 1, modulo 2**CNT_W.
- Other one-hot value (backwards skip, e.g. green→red):
  - `err_order` = 1.
  - Resync: `phase` = new value, `dwell` = 1, stay in TRACK, `valid` = 1.
  - No `cycle_count` change.

**Error flags**
- `err_any` sets on the same edge as any error pulse.
- Error pulses are 0 on every edge where no error condition occurs.

## Timing
- Reset (asynchronous on `rst_n` low, immediate):
  - `phase` = 11, `valid` = 0, `dwell` = 0, `cycle_count` = 0.
  - `err_onehot`, `err_order`, `err_dwell`, `err_any` all = 0.
  - FSM in IDLE.
- Latency: `light` sampled at edge N is reflected in all outputs immediately after edge N (1 cycle).
- First edge after reset release: behaves as IDLE with that sample.
- Reset asserted mid-sequence: all state is discarded; no error pulse is generated by the reset itself.
- `cycle_count` wraps 2**CNT_W−1 → 0 silently, with no error.
- `dwell` is saturation-only and never wraps.
- Throughput: one sample per clock, with no stall or backpressure.

## Test plan
- **Reset:** hold `rst_n` = 0 with `light` toggling → outputs stay at their reset values. Release with `light` = 100 → next edge `phase` = 00, `valid` = 1, `dwell` = 1, `cycle_count` = 0.
- **Legal run:** drive 100,010,001 repeated 4 full rounds, starting on green, with `MAX_DWELL` = 1 → after the final 100, `cycle_count` = 4. No error pulses; `err_any` = 0.
- **Dwell:** with `MAX_DWELL` = 3, hold 010 for 5 samples → `dwell` = 1,2,3,4,5. `err_dwell` = 1 only on the 4th sample; `err_any` = 1 thereafter.
- **Order error:** sequence 100,001 → `err_order` = 1 on the 001 edge, `phase` = 10, `dwell` = 1, `cycle_count` unchanged. A subsequent 100 counts as a legal cycle (`cycle_count` +1).
- **Non-one-hot:** in TRACK drive 110, then 000, then 010 →
  - 110: `err_onehot` = 1, `phase` = 11, `valid` = 0.
  - 000: no pulse.
  - 010: `phase` = 01, `valid` = 1, no `err_order`.
- **Wrap:** with `CNT_W` = 2, run 5 legal cycles → `cycle_count` sequence 1,2,3,0,1, with no errors.
